// File: rtl/a2d_pkg.sv
// Shared types and constants for the a2d_resp SPI response block.
package a2d_pkg;

  localparam int         FRAME_BITS = 16;
  localparam int         CHNL_LSB   = 11;
  localparam int         RES_W      = 12;
  localparam int         NUM_CH     = 8;
  localparam logic [7:0] LFSR_SEED  = 8'hA5;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // One step of the 8-bit Fibonacci LFSR, taps 8,6,5,4.
  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

endpackage

// File: rtl/a2d_resp_if.sv
// SPI pins between an external master and the a2d_resp slave.
interface a2d_resp_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;

  modport master (output SS_n, SCLK, MOSI, input MISO);
  modport slave  (input SS_n, SCLK, MOSI, output MISO);
endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer plus one edge-detect flop for one asynchronous pin.
module spi_sync_edge #(
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  // next values of the synchronizer chain
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // chain resets to the pin's idle level so reset creates no spurious edge
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= IDLE_LVL;
      sync_q <= IDLE_LVL;
      prev_q <= IDLE_LVL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~prev_q;
  assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/a2d_resp.sv
// a2d_resp: SPI slave that receives 16-bit command frames and returns the
// selected channel's conversion result in the following frame.
// Optional feature: define A2D_NOISE_EN to XOR an LFSR dither into results.
module a2d_resp #(
  parameter int NUM_CH = a2d_pkg::NUM_CH,
  parameter int RES_W  = a2d_pkg::RES_W
) (
  input  logic                    clk,
  input  logic                    rst,
  a2d_resp_if.slave               spi,
  input  logic [NUM_CH*RES_W-1:0] ana,
  output logic [15:0]             cmd,
  output logic [2:0]              chnnl,
  output logic                    cmd_vld,
  output logic                    frm_err
);

  import a2d_pkg::*;

  logic ss_lvl, ss_rise, ss_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic unused_sync;

  spi_sync_edge #(.IDLE_LVL(1'b1)) u_ss (
    .clk(clk), .rst(rst), .d(spi.SS_n),
    .level(ss_lvl), .rise(ss_rise), .fall(ss_fall)
  );
  spi_sync_edge #(.IDLE_LVL(1'b1)) u_sclk (
    .clk(clk), .rst(rst), .d(spi.SCLK),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync_edge #(.IDLE_LVL(1'b0)) u_mosi (
    .clk(clk), .rst(rst), .d(spi.MOSI),
    .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign unused_sync = ^{sclk_lvl, mosi_rise, mosi_fall};

  state_t state_q, state_d;
  logic   start, sample, drive, accept, reject;

  logic [FRAME_BITS-1:0] rx_shft_q, rx_shft_d;
  logic [FRAME_BITS-1:0] tx_shft_q, tx_shft_d;
  logic [FRAME_BITS-1:0] resp_q, resp_d;      // last loaded response, replayed at each frame start
  logic [4:0]            bit_cnt_q, bit_cnt_d;
  logic [15:0]           cmd_q, cmd_d;
  logic [2:0]            chnnl_q, chnnl_d;
  logic                  cmd_vld_q, cmd_vld_d;
  logic                  frm_err_q, frm_err_d;
  logic [2:0]            sel;
  logic [RES_W-1:0]      res;
  logic [FRAME_BITS-1:0] resp_new;
`ifdef A2D_NOISE_EN
  logic [7:0]            lfsr_q, lfsr_d;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next-state: frame opens on SS_n fall, closes on SS_n rise
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ss_fall) state_d = SHIFT;
      SHIFT:   if (ss_rise) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; SCLK edges outside SHIFT (incl. the SS_n-fall cycle) are dropped
  always_comb begin
    start  = 1'b0;
    sample = 1'b0;
    drive  = 1'b0;
    accept = 1'b0;
    reject = 1'b0;
    case (state_q)
      IDLE:  start = ss_fall;
      SHIFT: begin
        sample = sclk_rise;
        drive  = sclk_fall;
      end
      DONE: begin
        accept = (bit_cnt_q == 5'(FRAME_BITS));
        reject = (bit_cnt_q != 5'(FRAME_BITS));
      end
      default: ;
    endcase
  end

  // channel result picked from the command just received
  always_comb begin
    sel = rx_shft_q[CHNL_LSB +: 3];
    res = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (int'(sel) == c) res = ana[c*RES_W +: RES_W];
`ifdef A2D_NOISE_EN
    res = res ^ {{(RES_W-2){1'b0}}, lfsr_q[1:0]};
`endif
    resp_new = '0;
    resp_new[RES_W-1:0] = res;
  end

  // datapath next values
  always_comb begin
    rx_shft_d = rx_shft_q;
    tx_shft_d = tx_shft_q;
    resp_d    = resp_q;
    bit_cnt_d = bit_cnt_q;
    cmd_d     = cmd_q;
    chnnl_d   = chnnl_q;
    cmd_vld_d = accept;
    frm_err_d = reject;
    // reload from resp_q so an aborted (short) frame cannot corrupt the next reply
    if (start) begin
      bit_cnt_d = '0;
      tx_shft_d = resp_q;
    end
    if (sample) begin
      rx_shft_d = {rx_shft_q[FRAME_BITS-2:0], mosi_lvl};
      if (bit_cnt_q != 5'd31) bit_cnt_d = bit_cnt_q + 5'd1;
    end
    if (drive) tx_shft_d = {tx_shft_q[FRAME_BITS-2:0], 1'b0};
    if (accept) begin
      cmd_d     = rx_shft_q;
      chnnl_d   = sel;
      tx_shft_d = resp_new;
      resp_d    = resp_new;
    end
  end

  // datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_shft_q <= '0;
      tx_shft_q <= '0;
      resp_q    <= '0;
      bit_cnt_q <= '0;
      cmd_q     <= '0;
      chnnl_q   <= '0;
      cmd_vld_q <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      rx_shft_q <= rx_shft_d;
      tx_shft_q <= tx_shft_d;
      resp_q    <= resp_d;
      bit_cnt_q <= bit_cnt_d;
      cmd_q     <= cmd_d;
      chnnl_q   <= chnnl_d;
      cmd_vld_q <= cmd_vld_d;
      frm_err_q <= frm_err_d;
    end
  end

`ifdef A2D_NOISE_EN
  // dither LFSR steps once per accepted frame, after its value was used
  always_comb begin
    lfsr_d = lfsr_q;
    if (accept) lfsr_d = lfsr_next(lfsr_q);
  end

  // dither LFSR register
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end
`endif

  assign spi.MISO = tx_shft_q[FRAME_BITS-1] & ~ss_lvl;
  assign cmd      = cmd_q;
  assign chnnl    = chnnl_q;
  assign cmd_vld  = cmd_vld_q;
  assign frm_err  = frm_err_q;

endmodule

// File: tb/tb_a2d_resp.sv
// Directed bench for a2d_resp: bit-banged SPI master plus a scoreboard of
// expected MISO words (each frame's reply is pushed when the frame is sent).
module tb_a2d_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic [95:0] ana;
  logic [15:0] cmd;
  logic [2:0]  chnnl;
  logic        cmd_vld, frm_err;

  always #5 clk = ~clk;

  a2d_resp_if spi();

  a2d_resp #(.NUM_CH(8), .RES_W(12)) dut (
    .clk(clk), .rst(rst), .spi(spi), .ana(ana),
    .cmd(cmd), .chnnl(chnnl), .cmd_vld(cmd_vld), .frm_err(frm_err)
  );

  int          checks = 0;
  int          errors = 0;
  int          vld_cnt = 0;
  int          err_cnt = 0;
  logic [15:0] exp_q[$];
  logic [11:0] ana_m[8];
  logic [7:0]  lfsr_m;
  logic [15:0] cmd_m;

  // count pulse cycles seen on the strobes
  always @(posedge clk) begin
    if (cmd_vld) vld_cnt++;
    if (frm_err) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ana(input int ch, input logic [11:0] v);
    ana_m[ch] = v;
    ana[ch*12 +: 12] = v;
  endtask

  // reference reply for an accepted command on channel ch
  function automatic logic [15:0] model_resp(input logic [2:0] ch);
    logic [11:0] r;
    r = ana_m[ch];
`ifdef A2D_NOISE_EN
    r = r ^ {10'b0, lfsr_m[1:0]};
    lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
`endif
    return {4'h0, r};
  endfunction

  // one SPI frame; MISO sampled just before each SCLK fall; abort_at applies rst
  task automatic frame(input logic [15:0] w, input int nbits, input int abort_at,
                       output logic [15:0] mw, output int latency);
    mw = '0;
    latency = -1;
    spi.SS_n = 1'b0;
    wait_clk(4);
    for (int i = 0; i < nbits; i++) begin
      if (i == abort_at) begin
        rst = 1'b1; spi.SS_n = 1'b1; spi.SCLK = 1'b1; spi.MOSI = 1'b0;
        wait_clk(4);
        rst = 1'b0;
        wait_clk(2);
        return;
      end
      mw = {mw[14:0], spi.MISO};
      spi.MOSI = w[15-i];
      spi.SCLK = 1'b0;
      wait_clk(4);
      spi.SCLK = 1'b1;
      wait_clk(4);
    end
    spi.SS_n = 1'b1;
    for (int k = 1; k <= 8 && latency < 0; k++) begin
      @(negedge clk);
      if (cmd_vld | frm_err) latency = k;
    end
    wait_clk(4);
  endtask

  // send a frame and score reply, strobes, cmd/chnnl and pulse latency
  task automatic run(input string tag, input logic [15:0] w, input int nbits);
    int          v0, e0, lat;
    logic [15:0] mw, exp;
    v0 = vld_cnt;
    e0 = err_cnt;
    frame(w, nbits, -1, mw, lat);
    if (nbits == 16) begin
      if (exp_q.size() == 0) check({tag, "_sb_empty"}, 1, 0);
      else begin
        exp = exp_q.pop_front();
        check({tag, "_miso"}, mw, exp);
      end
      exp_q.push_back(model_resp(w[13:11]));
      cmd_m = w;
    end
    check({tag, "_vld"}, vld_cnt - v0, (nbits == 16) ? 1 : 0);
    check({tag, "_err"}, err_cnt - e0, (nbits == 16) ? 0 : 1);
    check({tag, "_cmd"}, cmd, cmd_m);
    check({tag, "_chnnl"}, chnnl, cmd_m[13:11]);
    check({tag, "_lat"}, (lat >= 1 && lat <= 4), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(2);
    lfsr_m = 8'hA5;
    cmd_m  = '0;
    exp_q.delete();
    exp_q.push_back(16'h0000);
  endtask

  initial begin
    logic [15:0] mw;
    int          lat, v0, e0;
    spi.SS_n = 1'b1; spi.SCLK = 1'b1; spi.MOSI = 1'b0;
    ana = '0;
    for (int c = 0; c < 8; c++) ana_m[c] = '0;
    do_reset();

    check("rst_cmd", cmd, 16'h0000);
    check("rst_chnnl", chnnl, 3'd0);
    check("rst_cmd_vld", cmd_vld, 1'b0);
    check("rst_frm_err", frm_err, 1'b0);
    check("rst_miso", spi.MISO, 1'b0);

    // reset after bit 7: no strobes, scoreboard still expects 0000 next
    set_ana(3, 12'hABC);
    v0 = vld_cnt; e0 = err_cnt;
    frame(16'h1800, 16, 8, mw, lat);
    do_reset();
    check("abort_vld", vld_cnt - v0, 0);
    check("abort_err", err_cnt - e0, 0);
    check("abort_cmd", cmd, 16'h0000);

    run("ch3_first", 16'h1800, 16);
    set_ana(3, 12'h555);           // not sampled until the next DONE on ch3
    set_ana(0, 12'h001);
    run("ch0", 16'h0000, 16);
    set_ana(7, 12'hFFF);
    run("ch7", 16'h3800, 16);
    set_ana(3, 12'hABC);
    run("ch3_again", 16'h1800, 16);
    run("short10", 16'h2800, 10);

    // SCLK activity with SS_n high must not reach the bit counter
    for (int t = 0; t < 5; t++) begin
      spi.MOSI = t[0];
      spi.SCLK = 1'b0; wait_clk(4);
      spi.SCLK = 1'b1; wait_clk(4);
    end
    spi.MOSI = 1'b0;
    set_ana(5, 12'h5A5);
    run("ch5_after_idle_sclk", 16'h2800, 16);
    run("tail", 16'hFFFF, 16);

    // two ch2 frames straight after reset (dithered when the noise build is used)
    do_reset();
    set_ana(2, 12'h100);
    run("ch2_a", 16'h1000, 16);
    run("ch2_b", 16'h1000, 16);
    run("ch2_tail", 16'h0000, 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
